// File: rtl/sign_compressor_pkg.sv
// Shared definitions for the sign_compressor narrowing encoder.
//   - mode encodings seen on in_mode
//   - FSM state encoding
//   - saturation limits for 16-bit signed beats
//   - beat_t: one outgoing halfword beat with its side flags
package sign_compressor_pkg;

  localparam logic [1:0] MODE_COMPACT = 2'd0;
  localparam logic [1:0] MODE_FULL    = 2'd1;
  localparam logic [1:0] MODE_SAT     = 2'd2;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        sat;
  } beat_t;

  // True when the upper half is nothing more than the sign extension of bit 15.
  function automatic logic fits16(input logic [31:0] w);
    return w[31:16] == {16{w[15]}};
  endfunction

endpackage

// File: rtl/sign_compressor_sat_counter.sv
// sat_counter: CNT_W-bit statistics counter that sticks at all-ones.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, takes priority over inc
//   cnt        : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sign_compressor.sv
// sign_compressor: narrows 32-bit words to 16-bit halfword beats.
// A word whose upper half is a sign copy of bit 15 may travel as one beat;
// otherwise it is sent low half then high half, or clamped to one saturated
// beat in SAT mode.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input word handshake
//   in_data, in_mode      : word and mode, sampled only on accept
//   out_valid/out_ready   : output beat handshake
//   out_data/out_last/out_sat : beat, final-beat flag, saturated flag
//   cnt_clr               : synchronous clear of the statistics counters
//   cnt_words/cnt_compact/cnt_sat : saturating statistics counters
module sign_compressor
  import sign_compressor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_sat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_compact,
  output logic [CNT_W-1:0] cnt_sat
);

  // First beat of a freshly accepted word; the high half, if needed, follows
  // from the holding register.
  function automatic beat_t first_beat(input logic [31:0] w, input logic [1:0] mode);
    beat_t b;
    b.data = w[15:0];
    b.last = 1'b0;
    b.sat  = 1'b0;
    case (mode)
      MODE_COMPACT: b.last = fits16(w);
      MODE_SAT: begin
        b.last = 1'b1;
        if (!fits16(w)) begin
          b.data = w[31] ? SAT_NEG : SAT_POS;
          b.sat  = 1'b1;
        end
      end
      default: b.last = 1'b0;  // FULL and the reserved code always send two beats
    endcase
    return b;
  endfunction

  state_t      state;
  logic [15:0] held_hi;
  beat_t       first_b;
  logic        out_fire;
  logic        accept;

  assign first_b  = first_beat(in_data, in_mode);
  assign out_fire = out_valid && out_ready;
  // A completing last beat frees the output register in the same cycle,
  // which lets back-to-back words stream without a bubble.
  assign in_ready = (state == IDLE) || (out_fire && out_last);
  assign accept   = in_valid && in_ready;

  // Output stage: FSM and registered beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      state     <= LO;
      out_valid <= 1'b1;
      out_data  <= first_b.data;
      out_last  <= first_b.last;
      out_sat   <= first_b.sat;
    end else if (out_fire) begin
      if ((state == LO) && !out_last) begin
        state    <= HI;
        out_data <= held_hi;
        out_last <= 1'b1;
        out_sat  <= 1'b0;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
        out_sat   <= 1'b0;
      end
    end
  end

  // The high half is only read from the LO state, which reset leaves, so the
  // holding register itself needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      held_hi <= in_data[31:16];
    end
  end

  logic inc_compact;
  logic inc_sat;

  assign inc_compact = accept && first_b.last && !first_b.sat;
  assign inc_sat     = accept && first_b.sat;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_words (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .clr   (cnt_clr),
    .cnt   (cnt_words)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_compact (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_compact),
    .clr   (cnt_clr),
    .cnt   (cnt_compact)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_sat (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_sat),
    .clr   (cnt_clr),
    .cnt   (cnt_sat)
  );

endmodule
